// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double-dabble) binary-to-BCD converter.
// It converts one value at a time. A start/busy/valid handshake controls it.
// Each conversion runs IN_W shift cycles and then one DONE cycle that
// publishes the result. When the input exceeds the largest value that
// DIGITS decimal digits can show, the output reads all nines and ovf is set.
module bin2bcd_seq #(
  parameter int IN_W   = 7,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + IN_W;
  localparam int CNT_W = $clog2(IN_W + 1);

  // Largest value DIGITS decimal digits can hold (10^DIGITS - 1). It is built
  // at the shift-register width, because 10^DIGITS < 16^DIGITS always fits.
  function automatic logic [SR_W-1:0] max_value();
    logic [SR_W-1:0] r;
    r = '0;
    for (int k = 0; k < DIGITS; k++) r = r * SR_W'(10) + SR_W'(9);
    return r;
  endfunction

  localparam logic [SR_W-1:0]  MAX_VAL  = max_value();
  localparam logic [BCD_W-1:0] ALL_NINE = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, next_state;
  logic [SR_W-1:0]   sr;        // {BCD field, remaining binary bits}
  logic [SR_W-1:0]   sr_adj;    // sr after the add-3 corrections
  logic [SR_W-1:0]   sr_step;   // sr after correction and shift
  logic [CNT_W-1:0]  cnt;
  logic              pend_ovf;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // samples pre-edge values, and the result does not depend on the order
    // in which the blocks are evaluated.
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: IDLE -> SHIFT for IN_W cycles -> DONE -> IDLE.
  always_comb begin
    // NOTE: the default assignment comes first, so every path drives
    // next_state and no latch is inferred.
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // One double-dabble step. All BCD nibbles are corrected in parallel.
  // A corrected nibble is at most 12, so no carry crosses into the next nibble.
  always_comb begin
    sr_adj = sr;
    for (int k = 0; k < DIGITS; k++) begin
      if (sr[IN_W + 4*k +: 4] >= 4'd5)
        sr_adj[IN_W + 4*k +: 4] = sr[IN_W + 4*k +: 4] + 4'd3;
    end
    sr_step = {sr_adj[SR_W-2:0], 1'b0};
  end

  // Datapath: load on acceptance, shift in SHIFT, publish in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      cnt      <= '0;
      pend_ovf <= 1'b0;
      valid    <= 1'b0;
      bcd_out  <= '0;
      ovf      <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sr       <= {BCD_W'(0), bin_in};
            cnt      <= CNT_W'(IN_W);
            pend_ovf <= (SR_W'(bin_in) > MAX_VAL);
          end
        end
        SHIFT: begin
          sr  <= sr_step;
          cnt <= cnt - CNT_W'(1);
        end
        DONE: begin
          bcd_out <= pend_ovf ? ALL_NINE : sr[SR_W-1:IN_W];
          ovf     <= pend_ovf;
          valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
